// File: rtl/hazard_pkg.sv
// Shared types for the RV32 hazard unit: forwarding selects, per-stage register tags
// and the liveness test applied to every tag comparison.
package hazard_pkg;

  // Widest register index the shadow tags can hold; narrower indices are zero-extended.
  localparam int TAG_RD_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                load;
  } stage_tag_t;

  localparam stage_tag_t TAG_INVALID = '{valid: 1'b0, rd: '0, reg_write: 1'b0, load: 1'b0};

  // x0 is hard-wired to zero, so a tag that targets it can never create a dependency.
  function automatic logic tag_live(input stage_tag_t t);
    return t.valid && t.reg_write && (t.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side request and hazard-control response bundle between the core pipeline
// (master) and the hazard unit (slave).
interface hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;
  logic                      reg_write_d;
  logic                      load_d;
  logic                      pc_src_e;

  logic                      stall_f;
  logic                      stall_d;
  logic                      stall_e;
  logic                      stall_m;
  logic                      flush_d;
  logic                      flush_e;
  logic                      flush_w;
  logic [1:0]                forward_a_e;
  logic [1:0]                forward_b_e;

  modport master (
    output valid_d, rs1_d, rs2_d, rd_d, reg_write_d, load_d, pc_src_e,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e
  );

  modport slave (
    input  valid_d, rs1_d, rs2_d, rd_d, reg_write_d, load_d, pc_src_e,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e
  );
endinterface

// File: rtl/hazard_tag_reg.sv
// One shadow pipeline-stage tag register; clear wins over hold so a bubble can be
// injected into a stage regardless of the stall state.
module hazard_tag_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_i,
  input  logic       clr_i,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  stage_tag_t tag_q;
  stage_tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (clr_i) begin
      tag_d = TAG_INVALID;
    end else if (!hold_i) begin
      tag_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= TAG_INVALID;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard resolution for the five-stage RV32 pipeline: forwarding, load-use stall,
// branch flush and multi-cycle load freeze. Define HAZARD_FORWARD_EN to enable forwarding.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LAT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hif
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  logic [CNT_W-1:0]    busy_cnt_q;
  logic [CNT_W-1:0]    busy_cnt_d;
  logic                busy;
  logic                raw_hazard;
  logic [TAG_RD_W-1:0] rs1_d_x;
  logic [TAG_RD_W-1:0] rs2_d_x;
  stage_tag_t          tag_in_d;
  stage_tag_t          tag_e;
  stage_tag_t          tag_m;
  stage_tag_t          tag_w;
  fwd_sel_t            fwd_a;
  fwd_sel_t            fwd_b;

  logic                stall_f;
  logic                stall_d;
  logic                stall_e;
  logic                stall_m;
  logic                flush_d;
  logic                flush_e;
  logic                flush_w;
  fwd_sel_t            fwd_a_out;
  fwd_sel_t            fwd_b_out;

  function automatic logic rd_hits(input stage_tag_t t, input logic [TAG_RD_W-1:0] a,
                                   input logic [TAG_RD_W-1:0] b);
    return tag_live(t) && ((t.rd == a) || (t.rd == b));
  endfunction

  assign rs1_d_x  = TAG_RD_W'(hif.rs1_d);
  assign rs2_d_x  = TAG_RD_W'(hif.rs2_d);
  assign tag_in_d = '{valid: hif.valid_d, rd: TAG_RD_W'(hif.rd_d),
                      reg_write: hif.reg_write_d, load: hif.load_d};
  assign busy     = (busy_cnt_q != '0);

`ifdef HAZARD_FORWARD_EN
  logic [TAG_RD_W-1:0] rs1_e_q;
  logic [TAG_RD_W-1:0] rs2_e_q;

  // A bubble in E has no operands, so it never selects a bypass path.
  function automatic fwd_sel_t fwd_pick(input logic [TAG_RD_W-1:0] rs, input logic e_valid,
                                        input stage_tag_t m, input stage_tag_t w);
    if (e_valid && tag_live(m) && (m.rd == rs)) begin
      return FWD_M;
    end else if (e_valid && tag_live(w) && (w.rd == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  // D -> E operand indices, held with the E tag during a memory freeze
  always_ff @(posedge clk) begin
    if (!busy) begin
      rs1_e_q <= rs1_d_x;
      rs2_e_q <= rs2_d_x;
    end
  end

  assign raw_hazard = hif.valid_d && tag_e.load && rd_hits(tag_e, rs1_d_x, rs2_d_x);
  assign fwd_a      = fwd_pick(rs1_e_q, tag_e.valid, tag_m, tag_w);
  assign fwd_b      = fwd_pick(rs2_e_q, tag_e.valid, tag_m, tag_w);
`else
  assign raw_hazard = hif.valid_d && (rd_hits(tag_e, rs1_d_x, rs2_d_x) ||
                                      rd_hits(tag_m, rs1_d_x, rs2_d_x) ||
                                      rd_hits(tag_w, rs1_d_x, rs2_d_x));
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
`endif

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    fwd_a_out = FWD_RF;
    fwd_b_out = FWD_RF;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a_out = fwd_a;
      fwd_b_out = fwd_b;
      if (busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hif.pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (raw_hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // A live load leaving E arms the freeze; the count then runs down to zero.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (busy) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end else if (tag_live(tag_e) && tag_e.load) begin
      busy_cnt_d = CNT_W'(LOAD_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // D -> E
  hazard_tag_reg u_tag_e (
    .clk    (clk),
    .rst    (rst),
    .hold_i (busy),
    .clr_i  (flush_e),
    .d_i    (tag_in_d),
    .q_o    (tag_e)
  );

  // E -> M
  hazard_tag_reg u_tag_m (
    .clk    (clk),
    .rst    (rst),
    .hold_i (busy),
    .clr_i  (1'b0),
    .d_i    (tag_e),
    .q_o    (tag_m)
  );

  // M -> W
  hazard_tag_reg u_tag_w (
    .clk    (clk),
    .rst    (rst),
    .hold_i (1'b0),
    .clr_i  (flush_w),
    .d_i    (tag_m),
    .q_o    (tag_w)
  );

  assign hif.stall_f     = stall_f;
  assign hif.stall_d     = stall_d;
  assign hif.stall_e     = stall_e;
  assign hif.stall_m     = stall_m;
  assign hif.flush_d     = flush_d;
  assign hif.flush_e     = flush_e;
  assign hif.flush_w     = flush_w;
  assign hif.forward_a_e = fwd_a_out;
  assign hif.forward_b_e = fwd_b_out;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (LOAD_LAT=3); expectations are hand-derived for both
// HAZARD_FORWARD_EN settings.
module tb_hazard_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  hazard_unit_if #(.REG_ADDR_WIDTH(5)) hif ();

  hazard_unit #(
    .REG_ADDR_WIDTH (5),
    .LOAD_LAT       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b}
  logic [10:0] obs;
  assign obs = {hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m,
                hif.flush_d, hif.flush_e, hif.flush_w, hif.forward_a_e, hif.forward_b_e};

  localparam logic [10:0] E_N    = 11'b0000_000_00_00;
  localparam logic [10:0] E_RST  = 11'b0000_111_00_00;
  localparam logic [10:0] E_LU   = 11'b1100_010_00_00;
  localparam logic [10:0] E_BUSY = 11'b1111_001_00_00;
  localparam logic [10:0] E_CF   = 11'b0000_110_00_00;

  function automatic logic [10:0] fw(input logic [1:0] a, input logic [1:0] b);
    return {7'b0, a, b};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input int rs1,
                      input int rs2, input int rd, input logic we, input logic ld,
                      input logic pc, input logic [10:0] want);
    @(negedge clk);
    rst             = r;
    hif.valid_d     = v;
    hif.rs1_d       = 5'(rs1);
    hif.rs2_d       = 5'(rs2);
    hif.rd_d        = 5'(rd);
    hif.reg_write_d = we;
    hif.load_d      = ld;
    hif.pc_src_e    = pc;
    #1;
    chk(tag, obs, want);
  endtask

  task automatic ins(input string tag, input int rs1, input int rs2, input int rd,
                     input logic we, input logic ld, input logic pc, input logic [10:0] want);
    step(tag, 1'b0, 1'b1, rs1, rs2, rd, we, ld, pc, want);
  endtask

  task automatic idle(input string tag, input logic [10:0] want);
    step(tag, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b1;
    hif.valid_d     = 1'b0;
    hif.rs1_d       = '0;
    hif.rs2_d       = '0;
    hif.rd_d        = '0;
    hif.reg_write_d = 1'b0;
    hif.load_d      = 1'b0;
    hif.pc_src_e    = 1'b0;

    step("rst0", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, E_RST);
    step("rst1", 1'b1, 1'b1, 1, 2, 5, 1'b1, 1'b1, 1'b1, E_RST);

    // add x5,x1,x2 ; add x6,x5,x3
    ins("t1_add5", 1, 2, 5, 1'b1, 1'b0, 1'b0, E_N);
`ifdef HAZARD_FORWARD_EN
    ins("t1_add6", 5, 3, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t1_fwd_m", fw(2'b10, 2'b00));
    idle("t1_drain0", E_N);
    idle("t1_drain1", E_N);
`else
    ins("t1_stall_e", 5, 3, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t1_stall_m", 5, 3, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t1_stall_w", 5, 3, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t1_go", 5, 3, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t1_drain0", E_N);
    idle("t1_drain1", E_N);
`endif

    // lw x5,0(x0) ; add x6,x1,x5
    ins("t2_lw", 0, 0, 5, 1'b1, 1'b1, 1'b0, E_N);
    ins("t2_loaduse", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t2_frz1", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_BUSY);
    ins("t2_frz2", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_BUSY);
`ifdef HAZARD_FORWARD_EN
    ins("t2_resume", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t2_fwd_w", fw(2'b00, 2'b01));
    idle("t2_drain", E_N);
`else
    ins("t2_stall_m", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t2_stall_w", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_LU);
    ins("t2_resume", 1, 5, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t2_drain0", E_N);
    idle("t2_drain1", E_N);
`endif

    // lw x5 in E, dependent add in D, branch taken: flush beats load-use
    ins("t3_lw", 0, 0, 5, 1'b1, 1'b1, 1'b0, E_N);
    ins("t3_ctrl_flush", 1, 5, 6, 1'b1, 1'b0, 1'b1, E_CF);
    step("t3_pc_ignored", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, E_BUSY);
    idle("t3_frz2", E_BUSY);
    idle("t3_resume", E_N);
    idle("t3_drain", E_N);

    // lw x7 enters M with independent followers: exactly two frozen cycles
    ins("t4_lw7", 0, 0, 7, 1'b1, 1'b1, 1'b0, E_N);
    ins("t4_indep", 1, 2, 8, 1'b1, 1'b0, 1'b0, E_N);
    ins("t4_frz1", 3, 4, 9, 1'b1, 1'b0, 1'b0, E_BUSY);
    ins("t4_frz2", 3, 4, 9, 1'b1, 1'b0, 1'b0, E_BUSY);
    ins("t4_resume", 3, 4, 9, 1'b1, 1'b0, 1'b0, E_N);
    idle("t4_drain0", E_N);
    idle("t4_drain1", E_N);

    // addi x0,x0,5 ; add x6,x0,x0
    ins("t5_addi_x0", 0, 0, 0, 1'b1, 1'b0, 1'b0, E_N);
    ins("t5_add_x0x0", 0, 0, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t5_no_fwd_x0", E_N);
    idle("t5_drain", E_N);

    // reset during the first frozen cycle
    ins("t6_lw7", 0, 0, 7, 1'b1, 1'b1, 1'b0, E_N);
    idle("t6_lw_in_e", E_N);
    step("t6_rst_in_frz", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, E_RST);
    ins("t6_after_rst", 7, 0, 9, 1'b1, 1'b0, 1'b0, E_N);
    idle("t6_tags_clear", E_N);
    idle("t6_drain", E_N);

`ifdef HAZARD_FORWARD_EN
    // two writers of x5 in flight: the younger (M) wins
    ins("t7_add5a", 1, 2, 5, 1'b1, 1'b0, 1'b0, E_N);
    ins("t7_add5b", 3, 4, 5, 1'b1, 1'b0, 1'b0, E_N);
    ins("t7_use", 5, 5, 6, 1'b1, 1'b0, 1'b0, E_N);
    idle("t7_m_over_w", fw(2'b10, 2'b10));
    idle("t7_drain", E_N);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
